// File: rtl/alu_seq.sv
// Handshaked ALU: single-cycle logic/arith ops, iterative shift-add multiply
// and restoring divide, with a result register held until the consumer takes it.
//
// state | meaning
// IDLE  | in_ready high, waiting for an op
// MUL   | shift-add multiply, one multiplier bit per cycle
// DIV   | restoring divide, one quotient bit per cycle
// DONE  | out_valid high, result held until out_ready
module alu_seq #(
  parameter int WIDTH = 16,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       control,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             z,
  output logic             g,
  output logic             div0
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MUL  = 2'd1;
  localparam logic [1:0] S_DIV  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0]    LAST = CW'(WIDTH - 1);
  localparam logic [WIDTH-1:0] WLIM = WIDTH'(WIDTH);

  localparam logic [3:0] OP_SUB = 4'd2;
  localparam logic [3:0] OP_MUL = 4'd3;
  localparam logic [3:0] OP_DIV = 4'd4;
  localparam logic [3:0] OP_NOT = 4'd5;
  localparam logic [3:0] OP_SHL = 4'd6;
  localparam logic [3:0] OP_SHR = 4'd7;
  localparam logic [3:0] OP_AND = 4'd8;
  localparam logic [3:0] OP_OR  = 4'd9;

  logic [1:0]       state;
  logic [CW-1:0]    count;
  logic [WIDTH-1:0] acc;   // MUL partial product / DIV remainder
  logic [WIDTH-1:0] opa;   // MUL multiplicand / DIV dividend shifting into quotient
  logic [WIDTH-1:0] opb;   // MUL multiplier / DIV divisor

  logic [WIDTH-1:0] alu_res;
  logic [WIDTH-1:0] mul_next;
  logic [WIDTH:0]   rem_sh;
  logic [WIDTH:0]   rem_diff;
  logic [WIDTH-1:0] rem_next;
  logic             q_bit;
  logic [WIDTH-1:0] quo_next;
  logic             shift_big;
  logic             div_zero;

  assign in_ready  = (state == S_IDLE);
  assign out_valid = (state == S_DONE);

  assign shift_big = (b >= WLIM);
  assign div_zero  = (control == OP_DIV) && (b == '0);

  always_comb begin
    alu_res = a + b;
    case (control)
      OP_SUB: alu_res = a - b;
      OP_MUL: alu_res = '0;
      OP_DIV: alu_res = '1;
      OP_NOT: alu_res = ~a;
      OP_SHL: alu_res = shift_big ? '0 : (a << b[SHW-1:0]);
      OP_SHR: alu_res = shift_big ? '0 : (a >> b[SHW-1:0]);
      OP_AND: alu_res = a & b;
      OP_OR:  alu_res = a | b;
      default: alu_res = a + b;
    endcase
  end

  always_comb begin
    mul_next = opb[0] ? (acc + opa) : acc;
    rem_sh   = {acc, opa[WIDTH-1]};
    rem_diff = rem_sh - {1'b0, opb};
    q_bit    = ~rem_diff[WIDTH];
    rem_next = q_bit ? rem_diff[WIDTH-1:0] : rem_sh[WIDTH-1:0];
    quo_next = {opa[WIDTH-2:0], q_bit};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= S_IDLE;
      count  <= '0;
      acc    <= '0;
      opa    <= '0;
      opb    <= '0;
      result <= '0;
      z      <= 1'b0;
      g      <= 1'b0;
      div0   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            g     <= (a < b);
            div0  <= div_zero;
            opa   <= a;
            opb   <= b;
            acc   <= '0;
            count <= '0;
            if (control == OP_MUL) begin
              state <= S_MUL;
            end else if ((control == OP_DIV) && !div_zero) begin
              state <= S_DIV;
            end else begin
              result <= alu_res;
              z      <= (alu_res == '0);
              state  <= S_DONE;
            end
          end
        end
        S_MUL: begin
          acc   <= mul_next;
          opa   <= opa << 1;
          opb   <= opb >> 1;
          count <= count + 1'b1;
          if (count == LAST) begin
            result <= mul_next;
            z      <= (mul_next == '0);
            state  <= S_DONE;
          end
        end
        S_DIV: begin
          acc   <= rem_next;
          opa   <= quo_next;
          count <= count + 1'b1;
          if (count == LAST) begin
            result <= quo_next;
            z      <= (quo_next == '0);
            state  <= S_DONE;
          end
        end
        default: begin
          if (out_ready) state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
